// File: rtl/syn_lb_master.sv
// syn_lb_master: FIFO-buffered local-bus master, one transaction in flight; optional WAIT timeout via SYN_LB_MASTER_TIMEOUT_EN
module syn_lb_master #(
    parameter int LB_DATA_W      = 32,
    parameter int LB_ADDR_W      = 12,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 sys_clk_50,
    input  logic                 sys_rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_wr,
    input  logic [LB_ADDR_W-1:0] cmd_addr,
    input  logic [LB_DATA_W-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic                 rsp_wr,
    output logic [LB_DATA_W-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 lb_rd_en,
    output logic                 lb_wr_en,
    output logic [LB_ADDR_W-1:0] lb_addr,
    output logic [LB_DATA_W-1:0] lb_wr_data,
    input  logic                 lb_wr_valid,
    input  logic                 lb_rd_valid,
    input  logic [LB_DATA_W-1:0] lb_rd_data,
    output logic                 busy
);
    localparam int AW = $clog2(CMD_DEPTH);
    localparam int EW = 1 + LB_ADDR_W + LB_DATA_W;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t                 r_state;
    logic [EW-1:0]          r_mem [CMD_DEPTH];
    logic [AW:0]            r_wptr, r_rptr;
    logic                   r_wr, r_wr_en, r_rd_en, r_rsp_valid, r_rsp_wr;
    logic [LB_ADDR_W-1:0]   r_addr;
    logic [LB_DATA_W-1:0]   r_wdata, r_rdata;
    logic                   w_empty, w_full, w_push, w_done, w_to;
    logic [EW-1:0]          w_head;
    assign w_empty    = r_wptr == r_rptr;
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign cmd_ready  = !sys_rst && !w_full;
    assign w_push     = cmd_valid && cmd_ready;
    assign w_head     = r_mem[r_rptr[AW-1:0]];
    assign w_done     = r_state == WAIT && (r_wr ? lb_wr_valid : lb_rd_valid);
    assign busy       = r_state != IDLE || !w_empty;
    assign lb_wr_en   = r_wr_en;
    assign lb_rd_en   = r_rd_en;
    assign lb_addr    = r_addr;
    assign lb_wr_data = r_wdata;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_wr     = r_rsp_wr;
    assign rsp_rdata  = r_rdata;
`ifdef SYN_LB_MASTER_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_err;
    // The limit cycle times out only when no matching valid arrives in it.
    assign w_to    = r_state == WAIT && !w_done && r_cnt == 8'(TIMEOUT_CYCLES - 1);
    assign rsp_err = r_err;
    always_ff @(posedge sys_clk_50 or posedge sys_rst) begin
        if (sys_rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= r_state == WAIT ? r_cnt + 8'd1 : 8'd0;
            if (w_done || w_to) r_err <= w_to;
        end
    end
`else
    assign w_to    = 1'b0;
    assign rsp_err = 1'b0;
`endif
    always_ff @(posedge sys_clk_50) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= {cmd_wr, cmd_addr, cmd_wdata};
    end
    always_ff @(posedge sys_clk_50 or posedge sys_rst) begin
        if (sys_rst) r_wptr <= '0;
        else if (w_push) r_wptr <= r_wptr + 1'b1;
    end
    always_ff @(posedge sys_clk_50 or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= IDLE;
            r_rptr      <= '0;
            r_wr        <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_wr    <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: if (!w_empty) begin
                    r_state                 <= ISSUE;
                    r_rptr                  <= r_rptr + 1'b1;
                    {r_wr, r_addr, r_wdata} <= w_head;
                    r_wr_en                 <= w_head[EW-1];
                    r_rd_en                 <= !w_head[EW-1];
                end
                ISSUE: r_state <= WAIT;
                WAIT: if (w_done || w_to) begin
                    r_state     <= RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_wr    <= r_wr;
                    r_rdata     <= (w_done && !r_wr) ? lb_rd_data : '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_syn_lb_master.sv
// tb_syn_lb_master: randomized bench for syn_lb_master with a queue-based command/response model and a behavioural slave
module tb_syn_lb_master;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int TO = 8;
`ifdef SYN_LB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rd;
        int            d;
    } cmd_t;

    logic          sys_clk_50 = 1'b0, sys_rst = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid, rsp_wr, rsp_err, lb_rd_en, lb_wr_en, busy;
    logic [DW-1:0] rsp_rdata, lb_wr_data;
    logic [AW-1:0] lb_addr;
    logic          lb_wr_valid = 1'b0, lb_rd_valid = 1'b0;
    logic [DW-1:0] lb_rd_data = '0;

    int   n_tot = 0, n_bad = 0;
    int   cyc = 0, acc_cyc = 0, stb_cyc = 0, rsp_cyc = 0, stb_cnt = 0, rsp_cnt = 0, nexp = 0;
    cmd_t iq[$], rq[$];
    cmd_t pc;
    int   pcnt = 0;
    bit   pend = 0, nr_out = 0, prev_stb = 0, prev_rv = 0;

    syn_lb_master #(.LB_DATA_W(DW), .LB_ADDR_W(AW), .CMD_DEPTH(4), .TIMEOUT_CYCLES(TO)) dut (
        .sys_clk_50(sys_clk_50), .sys_rst(sys_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .lb_rd_en(lb_rd_en), .lb_wr_en(lb_wr_en), .lb_addr(lb_addr), .lb_wr_data(lb_wr_data),
        .lb_wr_valid(lb_wr_valid), .lb_rd_valid(lb_rd_valid), .lb_rd_data(lb_rd_data),
        .busy(busy)
    );

    always #10 sys_clk_50 = ~sys_clk_50;
    always @(posedge sys_clk_50) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // With the timeout build, no slave answer (d==0) or one past the limit ends in an error response.
    function automatic bit timed_out(input cmd_t c);
        return TO_EN && (c.d == 0 || c.d > TO);
    endfunction

    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] dat,
                        input logic [DW-1:0] rd, input int d);
        cmd_t c;
        int   k;
        c = '{wr, a, dat, rd, d};
        cmd_wr = wr; cmd_addr = a; cmd_wdata = dat; cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 300) begin
            @(negedge sys_clk_50);
            k++;
        end
        chk("accept", cmd_ready, 1);
        acc_cyc = cyc;
        iq.push_back(c);
        rq.push_back(c);
        nexp++;
        @(negedge sys_clk_50);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        int k;
        k = 0;
        while (rsp_cnt < n && k < 2000) begin
            @(negedge sys_clk_50);
            k++;
        end
        chk("rsp_count", rsp_cnt, n);
    endtask

    // Slave and monitor: strobes checked against acceptance order, responses against the expected outcome.
    always @(negedge sys_clk_50) begin
        if (sys_rst) begin
            prev_stb = 0;
            prev_rv  = 0;
        end else begin
            lb_wr_valid = 1'b0;
            lb_rd_valid = 1'b0;
            lb_rd_data  = $urandom;
            if (lb_wr_en || lb_rd_en) begin
                chk("stb_pulse", prev_stb, 0);
                chk("stb_excl", lb_wr_en & lb_rd_en, 0);
                stb_cyc = cyc;
                stb_cnt++;
                chk("stb_queued", iq.size() != 0, 1);
                if (iq.size() != 0) begin
                    pc = iq.pop_front();
                    chk("stb_wr", lb_wr_en, pc.wr);
                    chk("stb_addr", lb_addr, pc.addr);
                    if (pc.wr) chk("stb_wdata", lb_wr_data, pc.wdata);
                    pcnt   = pc.d;
                    pend   = pc.d != 0 && !timed_out(pc);
                    nr_out = !pend;
                end
            end else if (pend) begin
                chk("addr_hold", lb_addr, pc.addr);
                pcnt--;
                if (pcnt == 0) begin
                    pend = 0;
                    if (pc.wr) lb_wr_valid = 1'b1;
                    else begin
                        lb_rd_valid = 1'b1;
                        lb_rd_data  = pc.rd;
                    end
                end else if ($urandom_range(3) == 0) begin
                    if (pc.wr) lb_rd_valid = 1'b1;
                    else lb_wr_valid = 1'b1;
                end
            end else if (!nr_out && $urandom_range(3) == 0) begin
                lb_wr_valid = 1'($urandom_range(1));
                lb_rd_valid = 1'($urandom_range(1));
            end
            if (rsp_valid) begin
                cmd_t c;
                bit   t;
                chk("rsp_pulse", prev_rv, 0);
                chk("rsp_queued", rq.size() != 0, 1);
                if (rq.size() != 0) begin
                    c = rq.pop_front();
                    t = timed_out(c);
                    chk("rsp_wr", rsp_wr, c.wr);
                    chk("rsp_err", rsp_err, t);
                    chk("rsp_rdata", rsp_rdata, (t || c.wr) ? '0 : c.rd);
                end
                nr_out  = 0;
                rsp_cyc = cyc;
                rsp_cnt++;
            end
            prev_stb = lb_wr_en | lb_rd_en;
            prev_rv  = rsp_valid;
        end
    end

    initial begin
        int base;
        int k;
        #5 sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk_50);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {lb_wr_en, lb_rd_en}, 0);
        chk("rst_rsp", {rsp_valid, rsp_wr, rsp_err}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_lb_addr", lb_addr, 0);
        chk("rst_lb_wdata", lb_wr_data, 0);
        sys_rst = 1'b0;
        #1 chk("ready_after_rst", cmd_ready, 1);
        @(negedge sys_clk_50);

        send(1'b1, 12'h010, 32'hDEADBEEF, 32'h0, 3);
        wait_rsp(nexp);
        chk("wr_stb_latency", stb_cyc - acc_cyc, 2);
        chk("wr_rsp_latency", rsp_cyc - stb_cyc, 4);

        send(1'b0, 12'h0A4, $urandom, 32'h12345678, 1);
        wait_rsp(nexp);
        chk("rd_stb_latency", stb_cyc - acc_cyc, 2);
        chk("rd_rsp_latency", rsp_cyc - stb_cyc, 2);

        for (int i = 0; i < 5; i++)
            send(1'($urandom_range(1)), 12'($urandom), $urandom, $urandom, 6);
        chk("full_ready_low", cmd_ready, 0);
        chk("full_busy", busy, 1);
        send(1'b0, 12'h3FF, 32'h0, 32'hA5A5_5A5A, 2);
        wait_rsp(nexp);

`ifdef SYN_LB_MASTER_TIMEOUT_EN
        send(1'b0, 12'h0C0, 32'h0, 32'hFFFF_FFFF, 0);
        wait_rsp(nexp);
        chk("to_latency", rsp_cyc - stb_cyc, TO + 1);
        send(1'b0, 12'h0C4, 32'h0, 32'h0BAD_F00D, TO);
        wait_rsp(nexp);
        chk("limit_latency", rsp_cyc - stb_cyc, TO + 1);
`endif

        for (int i = 0; i < 60; i++) begin
            int d;
            d = $urandom_range(1, 6);
`ifdef SYN_LB_MASTER_TIMEOUT_EN
            if ($urandom_range(7) == 0) d = $urandom_range(1) ? 0 : TO + 1;
`endif
            send(1'($urandom_range(1)), 12'($urandom), $urandom, $urandom, d);
            repeat ($urandom_range(3)) @(negedge sys_clk_50);
        end
        wait_rsp(nexp);

        base = stb_cnt;
        send(1'b0, 12'h155, 32'h0, 32'h1111_2222, 0);
        k = 0;
        while (stb_cnt == base && k < 50) begin
            @(negedge sys_clk_50);
            k++;
        end
        chk("mid_rst_strobe_seen", stb_cnt, base + 1);
        repeat (3) @(negedge sys_clk_50);
        base = rsp_cnt;
        sys_rst = 1'b1;
        #1;
        chk("mid_rst_strobes", {lb_wr_en, lb_rd_en}, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp", rsp_valid, 0);
        chk("mid_rst_ready", cmd_ready, 0);
        iq.delete();
        rq.delete();
        pend = 0;
        nr_out = 0;
        nexp--;
        lb_wr_valid = 1'b0;
        lb_rd_valid = 1'b0;
        repeat (2) @(negedge sys_clk_50);
        sys_rst = 1'b0;
        repeat (5) @(negedge sys_clk_50);
        chk("mid_rst_no_rsp", rsp_cnt, base);
        chk("mid_rst_idle", busy, 0);
        chk("mid_rst_ready_back", cmd_ready, 1);
        send(1'b1, 12'h200, 32'hCAFE_0001, 32'h0, 2);
        wait_rsp(nexp);
        chk("post_rst_latency", stb_cyc - acc_cyc, 2);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/syn_lb_master.md
SYN_LB_MASTER -- requirements
Module: syn_lb_master

Interface
REQ-001 SHALL have parameter LB_DATA_W, default 32, LB data width.
REQ-002 SHALL have parameter LB_ADDR_W, default 12, LB address width.
REQ-003 SHALL have parameter CMD_DEPTH, default 4, command FIFO depth (power of 2, >=2).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, max WAIT cycles before error (1..255).
REQ-005 SHALL have port sys_clk_50  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port sys_rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port cmd_valid  input  1  command present.
REQ-008 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-009 SHALL have port cmd_wr  input  1  1=write, 0=read.
REQ-010 SHALL have port cmd_addr  input  LB_ADDR_W  target address.
REQ-011 SHALL have port cmd_wdata  input  LB_DATA_W  write data.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-013 SHALL have port rsp_wr  output  1  response belongs to a write.
REQ-014 SHALL have port rsp_rdata  output  LB_DATA_W  read data.
REQ-015 SHALL have port rsp_err  output  1  transaction timed out.
REQ-016 SHALL have ports lb_rd_en, lb_wr_en  output  1 each  LB strobes to slave.
REQ-017 SHALL have ports lb_addr  output  LB_ADDR_W, lb_wr_data  output  LB_DATA_W.
REQ-018 SHALL have ports lb_wr_valid, lb_rd_valid  input  1 each, lb_rd_data  input  LB_DATA_W  slave completion.
REQ-019 SHALL have port busy  output  1  high when FSM not IDLE or FIFO non-empty.

Function
REQ-020 SHALL buffer commands in a CMD_DEPTH FIFO; cmd_ready = FIFO not full; push on cmd_valid&cmd_ready.
REQ-021 SHALL run FSM IDLE->ISSUE->WAIT->RESP->IDLE; IDLE->ISSUE when FIFO non-empty, popping head on that transition.
REQ-022 SHALL, in ISSUE, assert exactly one of lb_wr_en/lb_rd_en (per cmd_wr) for exactly one cycle.
REQ-023 SHALL hold lb_addr/lb_wr_data stable from ISSUE through end of WAIT; both strobes low in all other states.
REQ-024 SHALL give minimum latency: command accepted cycle N -> strobe high cycle N+2.
REQ-025 SHALL sample lb_wr_valid (write) or lb_rd_valid (read) only in WAIT; completion inputs in IDLE/ISSUE/RESP and wrong-type valid SHALL be ignored.
REQ-026 SHALL, on matching valid in WAIT, capture lb_rd_data (read) or zero (write) and go to RESP next cycle.
REQ-027 SHALL, in RESP, pulse rsp_valid one cycle with rsp_wr, rsp_rdata, rsp_err registered; no response backpressure.
REQ-028 SHALL allow a push in the same cycle as a pop when FIFO full-minus-zero is not asserted; full FIFO with pop SHALL still hold cmd_ready low that cycle.
REQ-029 SHALL keep FIFO pointers wrapping modulo CMD_DEPTH with extra MSB for full/empty.
REQ-030 SHALL issue commands strictly in acceptance order, one outstanding transaction at a time.

Reset
REQ-031 SHALL on sys_rst asynchronously force FSM=IDLE, FIFO empty, timeout counter 0.
REQ-032 SHALL reset outputs: cmd_ready=0 while sys_rst high, 1 after; rsp_valid, rsp_wr, rsp_err, lb_rd_en, lb_wr_en, busy=0; rsp_rdata, lb_addr, lb_wr_data=0.
REQ-033 SHALL discard any in-flight transaction on reset mid-operation with no response emitted.

Configuration
REQ-034 SHALL, with SYN_LB_MASTER_TIMEOUT_EN defined, count WAIT cycles; on reaching TIMEOUT_CYCLES without valid go to RESP with rsp_err=1, rsp_rdata=0; valid in the limit cycle wins (rsp_err=0).
REQ-035 SHALL, without SYN_LB_MASTER_TIMEOUT_EN, omit the counter, wait indefinitely in WAIT, tie rsp_err=0.

Verification
REQ-036 SHALL cover: write addr 0x010 data 0xDEADBEEF, slave wr_valid 3 cycles after strobe -> one lb_wr_en pulse at N+2, rsp_valid with rsp_wr=1, rsp_err=0.
REQ-037 SHALL cover: read 0x0A4, slave returns 0x12345678 after 1 cycle -> rsp_rdata=0x12345678, rsp_wr=0.
REQ-038 SHALL cover: push 5 commands back-to-back, slave slow -> cmd_ready low after 4 buffered, all 5 responses in order.
REQ-039 SHALL cover (TIMEOUT_EN, TIMEOUT_CYCLES=8): read with no valid -> rsp_err=1, rsp_rdata=0 after 8 WAIT cycles; valid on 8th cycle -> rsp_err=0.
REQ-040 SHALL cover: sys_rst asserted during WAIT -> strobes/busy 0 immediately, no rsp_valid, FIFO empty; next command completes normally.
